// File: rtl/data_path_pkg.sv
// data_path_pkg: datapath width, ALU op encodings and bus-source priority shared by the datapath files
package data_path_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_NEG,
    ALU_SHL, ALU_SHR, ALU_SHRA, ALU_ROL, ALU_ROR, ALU_MUL
  } alu_op_e;
  typedef enum logic [3:0] {
    BUS_PC, BUS_MDR, BUS_ZLO, BUS_ZHI, BUS_R1, BUS_R2, BUS_R3, BUS_R4, BUS_NONE
  } bus_src_e;
  // s = {PCout,MDRout,Zlowout,Zhighout,R1out,R2out,R3out,R4out}; the highest set bit wins
  function automatic bus_src_e bus_sel(input logic [7:0] s);
    bus_src_e r;
    r = BUS_NONE;
    for (int i = 0; i < 8; i++) if (s[i]) r = bus_src_e'(4'(7 - i));
    return r;
  endfunction
endpackage

// File: rtl/data_path_if.sv
// data_path_if: sequencer strobes, ALU select, memory read data in; bus_out, pc_q, ir_q, mar_q out
interface data_path_if;
  import data_path_pkg::*;
  logic R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out;
  logic PCin, PCout, IRin, MARin, MDRin, MDRout, MD_read;
  logic Yin, Zlowin, Zlowout, Zhighout, IncPC;
  logic [3:0] alu_op;
  logic [WIDTH-1:0] Mdatain, bus_out, pc_q, ir_q, mar_q;
  modport master (
    output R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out,
    output PCin, PCout, IRin, MARin, MDRin, MDRout, MD_read,
    output Yin, Zlowin, Zlowout, Zhighout, IncPC, alu_op, Mdatain,
    input  bus_out, pc_q, ir_q, mar_q
  );
  modport slave (
    input  R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out,
    input  PCin, PCout, IRin, MARin, MDRin, MDRout, MD_read,
    input  Yin, Zlowin, Zlowout, Zhighout, IncPC, alu_op, Mdatain,
    output bus_out, pc_q, ir_q, mar_q
  );
endinterface

// File: rtl/data_path_alu.sv
// data_path_alu: combinational ALU; a_i=Y, b_i=bus, op_i select, inc_i forces b_i+1; r_o 64-bit result
module data_path_alu
  import data_path_pkg::*;
(
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [3:0]         op_i,
  input  logic               inc_i,
  output logic [2*WIDTH-1:0] r_o
);
  logic [5:0] sh, rl;
  logic [2*WIDTH-1:0] aa, mul;
  logic [WIDTH-1:0] lo;
  assign sh = {1'b0, b_i[4:0]};
  assign rl = 6'(WIDTH) - sh;
  // rotates are windows into A duplicated end to end
  assign aa = {a_i, a_i};
  assign mul = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  always_comb begin
    case (op_i)
      ALU_ADD:  lo = a_i + b_i;
      ALU_SUB:  lo = a_i - b_i;
      ALU_AND:  lo = a_i & b_i;
      ALU_OR:   lo = a_i | b_i;
      ALU_XOR:  lo = a_i ^ b_i;
      ALU_NOT:  lo = ~b_i;
      ALU_NEG:  lo = -b_i;
      ALU_SHL:  lo = a_i << sh;
      ALU_SHR:  lo = a_i >> sh;
      ALU_SHRA: lo = $signed(a_i) >>> sh;
      ALU_ROL:  lo = aa[rl +: WIDTH];
      ALU_ROR:  lo = aa[sh +: WIDTH];
      default:  lo = '0;
    endcase
  end
  assign r_o = inc_i ? {{WIDTH{1'b0}}, b_i + 1'b1}
             : op_i == ALU_MUL ? mul
             : {{WIDTH{1'b0}}, lo};
endmodule

// File: rtl/data_path.sv
// data_path: single-bus CPU datapath; clock, clear (sync active-high) and data_path_if.slave dp
module data_path
  import data_path_pkg::*;
(
  input logic        clock,
  input logic        clear,
  data_path_if.slave dp
);
  logic [WIDTH-1:0] r1_q, r2_q, r3_q, r4_q, pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [WIDTH-1:0] r1_d, r2_d, r3_d, r4_d, pc_d, ir_d, mar_d, mdr_d, y_d;
  logic [WIDTH-1:0] bus;
  logic [2*WIDTH-1:0] z_q, z_d, alu_r;
  bus_src_e src;
  assign src = bus_sel({dp.PCout, dp.MDRout, dp.Zlowout, dp.Zhighout,
                        dp.R1out, dp.R2out, dp.R3out, dp.R4out});
  always_comb begin
    case (src)
      BUS_PC:  bus = pc_q;
      BUS_MDR: bus = mdr_q;
      BUS_ZLO: bus = z_q[WIDTH-1:0];
      BUS_ZHI: bus = z_q[2*WIDTH-1:WIDTH];
      BUS_R1:  bus = r1_q;
      BUS_R2:  bus = r2_q;
      BUS_R3:  bus = r3_q;
      BUS_R4:  bus = r4_q;
      default: bus = '0;
    endcase
  end
  data_path_alu u_alu (
    .a_i   (y_q),
    .b_i   (bus),
    .op_i  (dp.alu_op),
    .inc_i (dp.IncPC),
    .r_o   (alu_r)
  );
  always_comb begin
    r1_d  = dp.R1in  ? bus : r1_q;
    r2_d  = dp.R2in  ? bus : r2_q;
    r3_d  = dp.R3in  ? bus : r3_q;
    r4_d  = dp.R4in  ? bus : r4_q;
    pc_d  = dp.PCin  ? bus : pc_q;
    ir_d  = dp.IRin  ? bus : ir_q;
    mar_d = dp.MARin ? bus : mar_q;
    y_d   = dp.Yin   ? bus : y_q;
    mdr_d = dp.MDRin ? (dp.MD_read ? dp.Mdatain : bus) : mdr_q;
    z_d   = dp.Zlowin ? alu_r : z_q;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end
  assign dp.bus_out = bus;
  assign dp.pc_q    = pc_q;
  assign dp.ir_q    = ir_q;
  assign dp.mar_q   = mar_q;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench for data_path driving sequencer micro-steps
module tb_data_path;
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  logic clk = 0;
  logic clr;
  int checks = 0;
  int errors = 0;
  exp_t bus_q[$];
  exp_t reg_q[$];
  logic [31:0] a, b;
  logic [63:0] m;
  data_path_if dpi ();
  data_path u_dut (.clock(clk), .clear(clr), .dp(dpi));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    clr = 0;
    {dpi.R1in, dpi.R2in, dpi.R3in, dpi.R4in, dpi.R1out, dpi.R2out, dpi.R3out, dpi.R4out} = '0;
    {dpi.PCin, dpi.PCout, dpi.IRin, dpi.MARin, dpi.MDRin, dpi.MDRout, dpi.MD_read} = '0;
    {dpi.Yin, dpi.Zlowin, dpi.Zlowout, dpi.Zhighout, dpi.IncPC} = '0;
    dpi.alu_op = 4'd0;
  endtask
  task automatic eb(input string tag, input logic [31:0] v);
    bus_q.push_back('{tag, 0, v});
  endtask
  task automatic er(input string tag, input int k, input logic [31:0] v);
    reg_q.push_back('{tag, k, v});
  endtask
  // bus expectations are checked mid-cycle, register expectations just after the edge
  task automatic step();
    exp_t e;
    #1;
    while (bus_q.size() > 0) begin
      e = bus_q.pop_front();
      chk(e.tag, dpi.bus_out, e.exp);
    end
    @(posedge clk);
    #1;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      chk(e.tag, e.kind == 1 ? dpi.pc_q : e.kind == 2 ? dpi.ir_q : dpi.mar_q, e.exp);
    end
    idle();
  endtask
  task automatic mem_load(input logic [31:0] v);
    dpi.Mdatain = v; dpi.MD_read = 1; dpi.MDRin = 1; step();
  endtask
  function automatic logic [63:0] model(input int op, input logic [31:0] x, input logic [31:0] y);
    int s;
    logic [31:0] r;
    s = int'(y[4:0]);
    r = 32'h0;
    if (op == 0) r = x + y;
    if (op == 1) r = x - y;
    if (op == 2) r = x & y;
    if (op == 3) r = x | y;
    if (op == 4) r = x ^ y;
    if (op == 5) r = ~y;
    if (op == 6) r = 32'h0 - y;
    if (op == 7) r = x << s;
    if (op == 8) r = x >> s;
    if (op == 9) r = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
    if (op == 10) r = (x << s) | (x >> (32 - s));
    if (op == 11) r = (x >> s) | (x << (32 - s));
    if (op == 12) return 64'(signed'(x)) * 64'(signed'(y));
    return {32'h0, r};
  endfunction
  initial begin
    idle();
    dpi.Mdatain = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    mem_load(32'hA5);
    dpi.MDRout = 1; dpi.PCin = 1; dpi.IRin = 1; dpi.MARin = 1; er("pre_pc", 1, 32'hA5); step();
    clr = 1; dpi.MDRout = 1; dpi.MD_read = 1; dpi.Mdatain = 32'hFFFF_FFFF;
    {dpi.R1in, dpi.R2in, dpi.R3in, dpi.R4in, dpi.PCin, dpi.IRin, dpi.MARin, dpi.MDRin, dpi.Yin, dpi.Zlowin} = '1;
    er("rst_pc", 1, 0); er("rst_ir", 2, 0); er("rst_mar", 3, 0); step();
    eb("rst_idle_bus", 0); step();
    dpi.MDRout = 1; eb("rst_mdr", 0); step();
    dpi.Zlowout = 1; eb("rst_zlo", 0); step();
    mem_load(32'h12);
    dpi.MDRout = 1; dpi.R2in = 1; eb("mdrout_bus", 32'h12); step();
    dpi.R2out = 1; eb("r2_load", 32'h12); step();
    mem_load(32'h14);
    dpi.MDRout = 1; dpi.R3in = 1; step();
    dpi.R2out = 1; dpi.Yin = 1; step();
    dpi.R3out = 1; dpi.alu_op = 4'd3; dpi.Zlowin = 1; eb("r3_bus", 32'h14); step();
    dpi.Zlowout = 1; dpi.R1in = 1; eb("or_zlo", 32'h16); step();
    dpi.R1out = 1; eb("or_r1", 32'h16); step();
    dpi.R1out = 1; dpi.MARin = 1; er("mar_pre", 3, 32'h16); step();
    dpi.PCout = 1; dpi.MARin = 1; dpi.IncPC = 1; dpi.Zlowin = 1; eb("fetch_pc_bus", 0); er("fetch_mar", 3, 0); step();
    dpi.Mdatain = 32'h1; dpi.Zlowout = 1; dpi.PCin = 1; dpi.MD_read = 1; dpi.MDRin = 1;
    eb("fetch_z", 1); er("fetch_pc", 1, 1); step();
    dpi.MDRout = 1; dpi.IRin = 1; eb("fetch_mdr", 1); er("fetch_ir", 2, 1); step();
    dpi.PCout = 1; dpi.MARin = 1; dpi.IncPC = 1; dpi.Zlowin = 1; er("fetch2_mar", 3, 1); step();
    dpi.Zlowout = 1; dpi.PCin = 1; er("fetch2_pc", 1, 2); step();
    a = 32'h8000_00F3; b = 32'h24;
    mem_load(a);
    dpi.MDRout = 1; dpi.Yin = 1; step();
    for (int op = 0; op < 14; op++) begin
      mem_load(b);
      dpi.MDRout = 1; dpi.alu_op = 4'(op); dpi.Zlowin = 1; step();
      m = model(op, a, b);
      dpi.Zlowout = 1; eb($sformatf("op%0d_lo", op), m[31:0]); step();
      dpi.Zhighout = 1; eb($sformatf("op%0d_hi", op), m[63:32]); step();
    end
    dpi.MDRout = 1; dpi.IncPC = 1; dpi.alu_op = 4'd1; dpi.Zlowin = 1; step();
    dpi.Zlowout = 1; eb("inc_lo", b + 1); step();
    dpi.Zhighout = 1; eb("inc_hi", 0); step();
    mem_load(32'hFFFF_FFFF);
    dpi.MDRout = 1; dpi.Yin = 1; step();
    mem_load(32'h1);
    dpi.MDRout = 1; dpi.alu_op = 4'd0; dpi.Zlowin = 1; step();
    dpi.Zlowout = 1; eb("add_wrap_lo", 0); step();
    dpi.Zhighout = 1; eb("add_wrap_hi", 0); step();
    mem_load(32'hFFFF_FFFD);
    dpi.MDRout = 1; dpi.Yin = 1; step();
    mem_load(32'h5);
    dpi.MDRout = 1; dpi.alu_op = 4'd12; dpi.Zlowin = 1; step();
    dpi.Zlowout = 1; eb("mul_lo", 32'hFFFF_FFF1); step();
    dpi.Zhighout = 1; eb("mul_hi", 32'hFFFF_FFFF); step();
    dpi.PCout = 1; dpi.MDRout = 1; eb("pri_pc_mdr", 32'h2); step();
    dpi.MDRout = 1; dpi.Zlowout = 1; eb("pri_mdr_zlo", 32'h5); step();
    dpi.Zlowout = 1; dpi.Zhighout = 1; eb("pri_zlo_zhi", 32'hFFFF_FFF1); step();
    dpi.Zhighout = 1; dpi.R1out = 1; eb("pri_zhi_r1", 32'hFFFF_FFFF); step();
    dpi.R1out = 1; dpi.R2out = 1; eb("pri_r1_r2", 32'h16); step();
    dpi.R2out = 1; dpi.R3out = 1; eb("pri_r2_r3", 32'h12); step();
    dpi.R3out = 1; dpi.R4out = 1; eb("pri_r3_r4", 32'h14); step();
    dpi.R4out = 1; eb("r4_zero", 0); step();
    mem_load(32'h55);
    dpi.MDRout = 1; dpi.R1in = 1; step();
    dpi.R1out = 1; eb("r1_55", 32'h55); step();
    clr = 1; dpi.MDRout = 1; dpi.R1in = 1; step();
    dpi.R1out = 1; eb("clr_r1", 0); step();
    dpi.PCout = 1; dpi.IncPC = 1; dpi.Zlowin = 1; eb("clr_pc_bus", 0); step();
    dpi.Zlowout = 1; dpi.PCin = 1; er("clr_inc_pc", 1, 1); step();
    mem_load(32'h33);
    dpi.MDRout = 1; dpi.R1in = 1; step();
    dpi.PCout = 1; dpi.R1out = 1; eb("pri_pc_r1", 32'h1); step();
    dpi.R1out = 1; eb("r1_33", 32'h33); step();
    eb("final_idle", 0); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
